lives_score_tracker: RTL

Per-game bookkeeping block that sits downstream of the game controller's per-pixel collision outputs and upstream of its end-of-game inputs. It collapses pixel-rate event levels into one event per frame. It maintains lives, the remaining-diamond count, a 5-digit BCD score and the post-death respawn timer. It returns `no_lives_left`, `no_dimond_left` and `player_awake` to the controller.

---
 rtl/lives_score_tracker_if.sv | 32 +++
 rtl/lives_score_tracker.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/lives_score_tracker_if.sv
// Bundle of the controller-facing signals of lives_score_tracker.
// The controller side uses the master modport, the tracker the slave modport.
interface lives_score_tracker_if;
    logic        startOfFrame;
    logic        restart_gameN;
    logic        reset_scoreN;
    logic [2:0]  game_state;
    logic        player_died;
    logic        player_eat_gold_1;
    logic        player_eat_diamond;
    logic        alien_died_a;
    logic [2:0]  lives;
    logic [5:0]  diamonds_left;
    logic [19:0] score_bcd;
    logic        player_awake;
    logic        no_lives_left;
    logic        no_dimond_left;

    modport master (
        output startOfFrame, restart_gameN, reset_scoreN, game_state,
               player_died, player_eat_gold_1, player_eat_diamond, alien_died_a,
        input  lives, diamonds_left, score_bcd, player_awake,
               no_lives_left, no_dimond_left
    );

    modport slave (
        input  startOfFrame, restart_gameN, reset_scoreN, game_state,
               player_died, player_eat_gold_1, player_eat_diamond, alien_died_a,
        output lives, diamonds_left, score_bcd, player_awake,
               no_lives_left, no_dimond_left
    );
endinterface

// File: rtl/lives_score_tracker.sv
// Per-game bookkeeping: folds pixel-rate event levels into one event per frame,
// keeps lives, remaining diamonds, a 5-digit BCD score and the respawn timer.
// There is no valid/ready handshake: events are levels sampled while playing,
// committed on the startOfFrame pulse; the score adder drains its award queue
// at one award per cycle and never back-pressures the commit.
module lives_score_tracker #(
    parameter logic [2:0]  NUM_LIVES      = 3'd3,
    parameter logic [5:0]  NUM_DIAMONDS   = 6'd40,
    parameter logic [19:0] DIAMOND_POINTS = 20'h00025,
    parameter logic [19:0] GOLD_POINTS    = 20'h00500,
    parameter logic [19:0] ALIEN_POINTS   = 20'h00250,
    parameter logic [7:0]  RESPAWN_FRAMES = 8'd60
) (
    input  logic                  clk,
    input  logic                  resetN,
    lives_score_tracker_if.slave  bus,
    output logic                  o_dbg_state
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ADD  = 1'b1;

    logic [2:0]  r_lives;
    logic [5:0]  r_diamonds;
    logic [19:0] r_score;
    logic        r_awake;
    logic        r_no_lives;
    logic        r_no_dia;
    logic [7:0]  r_resp_cnt;
    logic        r_pend_death, r_pend_gold, r_pend_dia, r_pend_alien;
    logic        r_q_gold, r_q_alien, r_q_dia;
    logic [0:0]  r_state;

    logic        w_playing, w_restart, w_clear, w_commit;
    logic        w_new_gold, w_new_alien, w_new_dia;
    logic        w_in_add;
    logic        w_ret_gold, w_ret_alien, w_ret_dia, w_any_ret;
    logic        w_q_gold_nxt, w_q_alien_nxt, w_q_dia_nxt, w_q_empty_nxt;
    logic [19:0] w_award;
    logic [19:0] w_score_sum;

    // Digit-wise BCD add with decimal carry; a carry out of the top digit
    // pins the result at the largest displayable score.
    function automatic logic [19:0] bcd_add(input logic [19:0] a, input logic [19:0] b);
        logic [19:0] sum;
        logic        carry;
        logic [4:0]  d;
        sum   = '0;
        carry = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, carry};
            if (d > 5'd9) begin
                d     = d + 5'd6;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            sum[4*i +: 4] = d[3:0];
        end
        if (carry) sum = 20'h99999;
        return sum;
    endfunction

    assign w_playing  = (bus.game_state == 3'd2);
    assign w_restart  = !bus.restart_gameN;
    assign w_clear    = !bus.reset_scoreN;
    // Restart overrides the frame commit entirely.
    assign w_commit   = bus.startOfFrame && !w_restart;

    assign w_new_gold  = w_commit && r_pend_gold;
    assign w_new_alien = w_commit && r_pend_alien;
    assign w_new_dia   = w_commit && r_pend_dia;

    // One award retired per ADD cycle, gold first, then alien, then diamond.
    assign w_in_add    = (r_state == ST_ADD);
    assign w_ret_gold  = w_in_add && r_q_gold;
    assign w_ret_alien = w_in_add && r_q_alien && !r_q_gold;
    assign w_ret_dia   = w_in_add && r_q_dia && !r_q_gold && !r_q_alien;
    assign w_any_ret   = w_ret_gold || w_ret_alien || w_ret_dia;

    assign w_q_gold_nxt  = (r_q_gold  && !w_ret_gold)  || w_new_gold;
    assign w_q_alien_nxt = (r_q_alien && !w_ret_alien) || w_new_alien;
    assign w_q_dia_nxt   = (r_q_dia   && !w_ret_dia)   || w_new_dia;
    assign w_q_empty_nxt = !(w_q_gold_nxt || w_q_alien_nxt || w_q_dia_nxt);

    assign w_award     = w_ret_gold ? GOLD_POINTS : (w_ret_alien ? ALIEN_POINTS : DIAMOND_POINTS);
    assign w_score_sum = bcd_add(r_score, w_award);

    // Sticky per-frame event flags; the commit clear wins over a same-cycle set.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_pend_death <= 1'b0;
            r_pend_gold  <= 1'b0;
            r_pend_dia   <= 1'b0;
            r_pend_alien <= 1'b0;
        end else if (w_restart || w_commit) begin
            r_pend_death <= 1'b0;
            r_pend_gold  <= 1'b0;
            r_pend_dia   <= 1'b0;
            r_pend_alien <= 1'b0;
        end else if (w_playing) begin
            if (bus.player_died)        r_pend_death <= 1'b1;
            if (bus.player_eat_gold_1)  r_pend_gold  <= 1'b1;
            if (bus.player_eat_diamond) r_pend_dia   <= 1'b1;
            if (bus.alien_died_a)       r_pend_alien <= 1'b1;
        end
    end

    // Lives, diamonds and respawn timer, updated once per committed frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_lives    <= NUM_LIVES;
            r_diamonds <= NUM_DIAMONDS;
            r_awake    <= 1'b1;
            r_resp_cnt <= 8'd0;
        end else if (w_restart) begin
            r_lives    <= NUM_LIVES;
            r_diamonds <= NUM_DIAMONDS;
            r_awake    <= 1'b1;
            r_resp_cnt <= 8'd0;
        end else if (w_commit) begin
            if (r_pend_death && r_awake) begin
                if (r_lives != 3'd0) r_lives <= r_lives - 3'd1;
                r_awake    <= 1'b0;
                r_resp_cnt <= RESPAWN_FRAMES;
            end else if (!r_awake && (r_lives != 3'd0)) begin
                // A death while asleep is dropped; the timer keeps running.
                if (r_resp_cnt <= 8'd1) begin
                    r_resp_cnt <= 8'd0;
                    r_awake    <= 1'b1;
                end else begin
                    r_resp_cnt <= r_resp_cnt - 8'd1;
                end
            end
            if (r_pend_dia && (r_diamonds != 6'd0)) r_diamonds <= r_diamonds - 6'd1;
        end
    end

    // Registered end-of-game flags; restart clears them so a stale 1 never
    // shows beside reloaded counters.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_no_lives <= 1'b0;
            r_no_dia   <= 1'b0;
        end else if (w_restart) begin
            r_no_lives <= 1'b0;
            r_no_dia   <= 1'b0;
        end else begin
            r_no_lives <= (r_lives == 3'd0);
            r_no_dia   <= (r_diamonds == 6'd0);
        end
    end

    // Award queue and adder FSM; restart and score clear abort any add.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_q_gold  <= 1'b0;
            r_q_alien <= 1'b0;
            r_q_dia   <= 1'b0;
            r_state   <= ST_IDLE;
        end else if (w_restart || w_clear) begin
            r_q_gold  <= 1'b0;
            r_q_alien <= 1'b0;
            r_q_dia   <= 1'b0;
            r_state   <= ST_IDLE;
        end else begin
            r_q_gold  <= w_q_gold_nxt;
            r_q_alien <= w_q_alien_nxt;
            r_q_dia   <= w_q_dia_nxt;
            case (r_state)
                ST_IDLE: if (r_q_gold || r_q_alien || r_q_dia) r_state <= ST_ADD;
                ST_ADD:  if (w_q_empty_nxt) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Score register: cleared on request, otherwise accumulates retired awards.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_score <= 20'h00000;
        end else if (w_clear) begin
            r_score <= 20'h00000;
        end else if (w_any_ret && !w_restart) begin
            r_score <= w_score_sum;
        end
    end

    assign bus.lives          = r_lives;
    assign bus.diamonds_left  = r_diamonds;
    assign bus.score_bcd      = r_score;
    assign bus.player_awake   = r_awake;
    assign bus.no_lives_left  = r_no_lives;
    assign bus.no_dimond_left = r_no_dia;
    assign o_dbg_state        = r_state;

endmodule
